// File: rtl/crc8_frame_checker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crc8_frame_checker_pkg : shared CRC-8 constants, FSM encodings, step helper |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package crc8_frame_checker_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One MSB-first LFSR step; the x^8 term is implicit in the shift-out of bit 7.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] poly);
        return {crc[6:0], 1'b0} ^ (crc[7] ? poly : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc8_frame_checker_bit_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crc8_frame_checker_bit_step : combinational single-bit CRC-8 advance       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module crc8_frame_checker_bit_step
    import crc8_frame_checker_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY
) (
    input  logic [7:0] crc_i,
    output logic [7:0] crc_o
);

    assign crc_o = crc8_step(crc_i, POLY);

endmodule
`default_nettype wire

// File: rtl/crc8_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crc8_frame_checker : bit-serial CRC-8 recompute and per-frame verdict      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module crc8_frame_checker
    import crc8_frame_checker_pkg::*;
#(
    parameter logic [7:0] POLY    = CRC8_POLY,
    parameter int         MAX_LEN = 255,
    parameter int         LEN_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [7:0]       data_i,
    input  logic             data_valid_i,
    input  logic             data_last_i,
    output logic             data_ready_o,
    output logic             frame_done_o,
    output logic             frame_ok_o,
    output logic             len_err_o,
    output logic [7:0]       crc_calc_o,
    output logic [7:0]       crc_recv_o,
    output logic [LEN_W-1:0] frame_len_o
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [1:0]       state_q, state_d;
    logic [7:0]       crc_q, crc_d;
    logic [7:0]       crc_shift;
    logic [2:0]       bit_q, bit_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             len_q, len_d;

    logic             ok_q, ok_d;
    logic             lerr_q, lerr_d;
    logic [7:0]       calc_q, calc_d;
    logic [7:0]       recv_q, recv_d;
    logic [LEN_W-1:0] flen_q, flen_d;

    logic             accept;
    logic             in_rx;

    crc8_frame_checker_bit_step #(
        .POLY (POLY)
    ) u_bit_step (
        .crc_i (crc_q),
        .crc_o (crc_shift)
    );

    assign in_rx        = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    // Gated by rst_ni so the handshake is silent while reset is asserted.
    assign data_ready_o = rst_ni & ~clear_i & in_rx;
    assign accept       = data_valid_i & data_ready_o;
    assign frame_done_o = (state_q == ST_DONE) & ~clear_i;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ok_d    = ok_q;
        lerr_d  = lerr_q;
        calc_d  = calc_q;
        recv_d  = recv_q;
        flen_d  = flen_q;

        if (clear_i) begin
            state_d = ST_IDLE;
            crc_d   = CRC8_INIT;
            bit_d   = 3'd0;
            cnt_d   = '0;
            len_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (state_q == ST_IDLE) begin
                        crc_d = CRC8_INIT;
                        cnt_d = '0;
                        len_d = 1'b0;
                    end
                    if (accept) begin
                        if (data_last_i) begin
                            recv_d  = data_i;
                            calc_d  = crc_d;
                            flen_d  = cnt_d;
                            lerr_d  = len_d;
                            ok_d    = (crc_d == data_i) && !len_d;
                            state_d = ST_DONE;
                        end else begin
                            // Overlong payload is still hashed; the count pins at MAX_LEN.
                            if (cnt_d == LEN_MAX) begin
                                len_d = 1'b1;
                            end else begin
                                cnt_d = cnt_d + LEN_W'(1);
                            end
                            crc_d   = crc_d ^ data_i;
                            bit_d   = 3'd0;
                            state_d = ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    crc_d = crc_shift;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    crc_d   = CRC8_INIT;
                    cnt_d   = '0;
                    len_d   = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            crc_q   <= CRC8_INIT;
            bit_q   <= 3'd0;
            cnt_q   <= '0;
            len_q   <= 1'b0;
            ok_q    <= 1'b0;
            lerr_q  <= 1'b0;
            calc_q  <= 8'h00;
            recv_q  <= 8'h00;
            flen_q  <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ok_q    <= ok_d;
            lerr_q  <= lerr_d;
            calc_q  <= calc_d;
            recv_q  <= recv_d;
            flen_q  <= flen_d;
        end
    end

    assign frame_ok_o  = ok_q;
    assign len_err_o   = lerr_q;
    assign crc_calc_o  = calc_q;
    assign crc_recv_o  = recv_q;
    assign frame_len_o = flen_q;

endmodule
`default_nettype wire
